// File: rtl/matmul_pkg.sv
// Shared constants, types and row-major element helpers for the sequential
// 3x3 matrix-multiply controller.
package matmul_pkg;

    localparam int N      = 3;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int IDX_W  = $clog2(N);
    localparam int NN     = N * N;
    localparam int AB_W   = NN * DATA_W;
    localparam int C_W    = NN * ACC_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    // Element [0][0] sits in the MSBs, so the LSB offset counts down from the top.
    function automatic int elem_lsb(input idx_t r, input idx_t c, input int w);
        return (NN - 1 - (int'(r) * N + int'(c))) * w;
    endfunction

    function automatic logic [DATA_W-1:0] get_op(input logic [AB_W-1:0] m,
                                                 input idx_t r, input idx_t c);
        return m[elem_lsb(r, c, DATA_W) +: DATA_W];
    endfunction

    function automatic logic [C_W-1:0] put_c(input logic [C_W-1:0] m,
                                             input idx_t r, input idx_t c,
                                             input logic [ACC_W-1:0] v);
        logic [C_W-1:0] res_s;
        res_s = m;
        res_s[elem_lsb(r, c, ACC_W) +: ACC_W] = v;
        return res_s;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single 16x16 multiply-accumulate unit with a registered accumulator; sum
// exposes this cycle's result so the controller can store it on the same edge.
module matmul_mac
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  sum
);

    logic [2*DATA_W-1:0] prod_s;
    logic [ACC_W-1:0]    acc_r;

    // Full-width unsigned product; the accumulation wraps modulo 2^ACC_W.
    always_comb begin
        prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        if (clear) begin
            sum = ACC_W'(prod_s);
        end else begin
            sum = acc_r + ACC_W'(prod_s);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= sum;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequential 3x3 matrix multiply: latches A/B, walks the 27 partial products
// through one MAC (k innermost, then j, then i) and presents C over valid/ready.
module matmul_seq_ctrl
    import matmul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AB_W-1:0] in_a,
    input  logic [AB_W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [C_W-1:0]  out_c,
    output logic            busy
);

    localparam idx_t IDX_MAX = idx_t'(N - 1);

    state_t          state_r, state_s;
    idx_t            i_r, j_r, k_r;
    logic [AB_W-1:0] a_r, b_r;
    logic [C_W-1:0]  c_r;
    logic [ACC_W-1:0] acc_s, sum_s;
    logic            accept_s, compute_s, last_s;

    assign accept_s  = in_valid && (state_r == IDLE);
    assign compute_s = (state_r == COMPUTE);
    assign last_s    = compute_s && (i_r == IDX_MAX) && (j_r == IDX_MAX) && (k_r == IDX_MAX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = COMPUTE;
                else          state_s = IDLE;
            end
            COMPUTE: begin
                if (last_s) state_s = DONE;
                else        state_s = COMPUTE;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, index walk and result storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
            i_r <= '0;
            j_r <= '0;
            k_r <= '0;
        end else if (accept_s) begin
            a_r <= in_a;
            b_r <= in_b;
            i_r <= '0;
            j_r <= '0;
            k_r <= '0;
        end else if (compute_s) begin
            if (k_r == IDX_MAX) begin
                c_r <= put_c(c_r, i_r, j_r, sum_s);
                k_r <= '0;
                if (j_r == IDX_MAX) begin
                    j_r <= '0;
                    i_r <= (i_r == IDX_MAX) ? idx_t'(0) : i_r + idx_t'(1);
                end else begin
                    j_r <= j_r + idx_t'(1);
                end
            end else begin
                k_r <= k_r + idx_t'(1);
            end
        end
    end

    matmul_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (compute_s),
        .clear (k_r == '0),
        .a     (get_op(a_r, i_r, k_r)),
        .b     (get_op(b_r, k_r, j_r)),
        .acc   (acc_s),
        .sum   (sum_s)
    );

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == COMPUTE) || (state_r == DONE);
    assign out_c     = c_r;

    logic unused_s;
    assign unused_s = ^acc_s;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: directed cases plus randomized
// operands with backpressure, checked against a plain-arithmetic golden model.
module tb_matmul_seq_ctrl;

    localparam int AB_W = 144;
    localparam int C_W  = 288;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [AB_W-1:0] in_a;
    logic [AB_W-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [C_W-1:0]  out_c;
    logic            busy;

    int n_checks;
    int n_fail;

    matmul_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [C_W-1:0] obs,
                             input logic [C_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // C[i][j] = sum_k A[i][k]*B[k][j] mod 2^32, row-major, [0][0] in MSBs.
    function automatic logic [C_W-1:0] golden(input logic [AB_W-1:0] a,
                                              input logic [AB_W-1:0] b);
        logic [15:0] ae [9];
        logic [15:0] be [9];
        logic [31:0] s;
        logic [C_W-1:0] c;
        c = '0;
        for (int e = 0; e < 9; e++) begin
            ae[e] = a[(8 - e) * 16 +: 16];
            be[e] = b[(8 - e) * 16 +: 16];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 32'd0;
                for (int k = 0; k < 3; k++) begin
                    s = s + 32'(ae[i * 3 + k]) * 32'(be[k * 3 + j]);
                end
                c[(8 - (i * 3 + j)) * 32 +: 32] = s;
            end
        end
        return c;
    endfunction

    function automatic logic [AB_W-1:0] rand_mat();
        logic [AB_W-1:0] m;
        for (int e = 0; e < 9; e++) begin
            m[e * 16 +: 16] = 16'($urandom);
        end
        return m;
    endfunction

    // One full transaction: accept, latency, backpressure stability, result, handshake.
    task automatic run_one(input logic [AB_W-1:0] a, input logic [AB_W-1:0] b,
                           input logic [C_W-1:0] exp, input int bp,
                           input bit hold, input logic [AB_W-1:0] na,
                           input logic [AB_W-1:0] nb, input bit noisy);
        logic [C_W-1:0] held;
        int cnt;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        check_val("in_ready_idle", C_W'(in_ready), C_W'(1));
        @(posedge clk);
        @(negedge clk);
        check_val("busy_compute", C_W'(busy), C_W'(1));
        check_val("in_ready_compute", C_W'(in_ready), C_W'(0));
        if (hold) begin
            in_a = na;
            in_b = nb;
        end else begin
            in_valid = 1'b0;
            in_a = rand_mat();
            in_b = rand_mat();
        end
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            if (noisy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cnt++;
            if (hold && !out_valid) check_val("in_ready_hold", C_W'(in_ready), C_W'(0));
        end
        out_ready = 1'b0;
        check_val("latency", C_W'(cnt), C_W'(27));
        check_val("result", out_c, exp);
        held = out_c;
        for (int n = 0; n < bp; n++) begin
            @(negedge clk);
            check_val("valid_stall", C_W'(out_valid), C_W'(1));
            check_val("c_stall", out_c, held);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("valid_drop", C_W'(out_valid), C_W'(0));
        check_val("in_ready_back", C_W'(in_ready), C_W'(1));
        check_val("busy_idle", C_W'(busy), C_W'(0));
    endtask

    logic [AB_W-1:0] ma, mb, ma2, mb2;
    logic [C_W-1:0]  cexp;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", C_W'(in_ready), C_W'(1));
        check_val("rst_out_valid", C_W'(out_valid), C_W'(0));
        check_val("rst_busy", C_W'(busy), C_W'(0));
        check_val("rst_out_c", out_c, '0);
        rst = 1'b0;
        @(negedge clk);

        // Identity times 1..9 gives B back.
        ma = '0;
        mb = '0;
        for (int r = 0; r < 3; r++) begin
            ma[(8 - (r * 3 + r)) * 16 +: 16] = 16'd1;
        end
        for (int e = 0; e < 9; e++) begin
            mb[(8 - e) * 16 +: 16] = 16'(e + 1);
        end
        cexp = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        run_one(ma, mb, cexp, 0, 1'b0, '0, '0, 1'b0);

        // All-ones operands exercise the 32-bit wrap of 3*0xFFFE0001.
        ma = {9{16'hFFFF}};
        cexp = {9{32'hFFFA0003}};
        run_one(ma, ma, cexp, 0, 1'b0, '0, '0, 1'b0);

        // Ten cycles of backpressure; handshake on the eleventh.
        ma = rand_mat();
        mb = rand_mat();
        run_one(ma, mb, golden(ma, mb), 10, 1'b0, '0, '0, 1'b0);

        // Second pair held valid throughout the first computation.
        ma  = rand_mat();
        mb  = rand_mat();
        ma2 = rand_mat();
        mb2 = rand_mat();
        run_one(ma, mb, golden(ma, mb), 2, 1'b1, ma2, mb2, 1'b0);
        run_one(ma2, mb2, golden(ma2, mb2), 0, 1'b0, '0, '0, 1'b0);

        // Reset in the middle of a computation.
        in_a = rand_mat();
        in_b = rand_mat();
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", C_W'(out_valid), C_W'(0));
        check_val("midrst_busy", C_W'(busy), C_W'(0));
        check_val("midrst_in_ready", C_W'(in_ready), C_W'(1));
        check_val("midrst_out_c", out_c, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_val("postrst_out_valid", C_W'(out_valid), C_W'(0));
        check_val("postrst_busy", C_W'(busy), C_W'(0));
        ma = rand_mat();
        mb = rand_mat();
        run_one(ma, mb, golden(ma, mb), 1, 1'b0, '0, '0, 1'b0);

        // Randomized back-to-back traffic with random backpressure.
        for (int t = 0; t < 200; t++) begin
            ma = rand_mat();
            mb = rand_mat();
            run_one(ma, mb, golden(ma, mb), $urandom_range(0, 3), 1'b0, '0, '0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
